// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - round-robin job scheduler for one shared FIR MAC engine; optional watchdog via FIR_SCHED_TIMEOUT_EN
module fir_mac_scheduler #(
  parameter int N_REQ          = 3,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [N_REQ-1:0] ack_o,
  output logic [SEL_W-1:0] eng_sel_o,
  output logic             eng_start_o,
  input  logic             eng_done_i,
  output logic             busy_o,
  output logic             eng_abort_o,
  output logic             timeout_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  // Parameter sanity: the owner index must fit eng_sel, and the watchdog limit must fit its 16-bit counter.
  if ((N_REQ < 2) || (N_REQ > 8) || ((1 << SEL_W) < N_REQ) ||
      (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65536)) begin : g_bad_params
    $error("fir_mac_scheduler: illegal parameter combination");
  end

  state_t           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] ack_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_ptr_q;
  logic             start_q;
  logic             busy_q;

  // Arbiter results, only consumed in IDLE
  logic [2*N_REQ-1:0] req_rot_d;
  logic [2*N_REQ-1:0] req_shift_d;
  logic               pick_valid_d;
  int                 pick_sum_d;
  logic [SEL_W-1:0]   pick_idx_d;
  logic [N_REQ-1:0]   pick_oh_d;

  // Round-robin pick: rotate the doubled request vector so that bit 0 is the requester just after last_ptr,
  // then take the lowest set bit and map its offset back to an absolute index.
  always_comb begin
    req_rot_d    = {req_i, req_i} >> (int'(last_ptr_q) + 1);
    req_shift_d  = '0;
    pick_valid_d = 1'b0;
    pick_sum_d   = 0;
    pick_idx_d   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_shift_d = req_rot_d >> k;
      if (!pick_valid_d && req_shift_d[0]) begin
        pick_valid_d = 1'b1;
        pick_sum_d   = int'(last_ptr_q) + 1 + k;
        if (pick_sum_d >= N_REQ) begin
          pick_sum_d = pick_sum_d - N_REQ;
        end
        pick_idx_d = SEL_W'(pick_sum_d);
      end
    end
    pick_oh_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_d;
  end

`ifdef FIR_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        abort_q;
  logic        terr_q;

  // Job sequencer with watchdog: grant, start, wait for done or timeout, acknowledge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      sel_q      <= '0;
      last_ptr_q <= SEL_W'(N_REQ - 1);
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      tmo_cnt_q  <= '0;
      abort_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid_d) begin
            state_q <= S_START;
            grant_q <= pick_oh_d;
            sel_q   <= pick_idx_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          state_q   <= S_BUSY;
          tmo_cnt_q <= '0;
        end
        S_BUSY: begin
          // Completion wins over a limit reached in the same cycle.
          if (eng_done_i) begin
            state_q    <= S_ACK;
            ack_q      <= grant_q;
            last_ptr_q <= sel_q;
          end else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= S_ACK;
            ack_q      <= grant_q;
            last_ptr_q <= sel_q;
            abort_q    <= 1'b1;
            terr_q     <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_abort_o   = abort_q;
  assign timeout_err_o = terr_q;
`else
  // Job sequencer: grant, start, wait for done, acknowledge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      sel_q      <= '0;
      last_ptr_q <= SEL_W'(N_REQ - 1);
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid_d) begin
            state_q <= S_START;
            grant_q <= pick_oh_d;
            sel_q   <= pick_idx_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (eng_done_i) begin
            state_q    <= S_ACK;
            ack_q      <= grant_q;
            last_ptr_q <= sel_q;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_abort_o   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  assign grant_o     = grant_q;
  assign ack_o       = ack_q;
  assign eng_sel_o   = sel_q;
  assign eng_start_o = start_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - self-checking bench for fir_mac_scheduler with a round-robin reference model
module tb_fir_mac_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic       eng_done = 1'b0;
  logic [2:0] grant;
  logic [2:0] ack;
  logic [1:0] eng_sel;
  logic       eng_start;
  logic       busy;
  logic       eng_abort;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  int m_last = 2;

  fir_mac_scheduler #(.N_REQ(3), .SEL_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .req_i        (req),
    .grant_o      (grant),
    .ack_o        (ack),
    .eng_sel_o    (eng_sel),
    .eng_start_o  (eng_start),
    .eng_done_i   (eng_done),
    .busy_o       (busy),
    .eng_abort_o  (eng_abort),
    .timeout_err_o(timeout_err)
  );

  always #5 clock = ~clock;

  // Reference: next owner is the first asserted requester after the last served one, circularly.
  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (((r >> i) & 3'b001) != 3'b000) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 3'b000; eng_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_last = 2;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
    checks++; if (eng_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", eng_sel); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", eng_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (eng_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", eng_abort); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
    reset = 1'b0; m_last = 2;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    req = 3'b010;
    tick();
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", eng_start); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", grant); end
    checks++; if (eng_sel !== 2'd1) begin errors++; $display("FAIL single_sel: got %0d expected 1", eng_sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick();
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", eng_start); end
    repeat (18) begin
      tick();
      checks++; if (ack !== 3'b000 || grant !== 3'b010) begin errors++; $display("FAIL single_hold: got ack=%b grant=%b expected ack=000 grant=010", ack, grant); end
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    checks++; if (ack !== 3'b010 || grant !== 3'b010) begin errors++; $display("FAIL single_ack: got ack=%b grant=%b expected ack=010 grant=010", ack, grant); end
    req = 3'b000; m_last = 1;
    tick();
    checks++; if (grant !== 3'b000 || ack !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got grant=%b ack=%b busy=%b expected 000 000 0", grant, ack, busy); end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    checks++; if (busy !== 1'b0 || ack !== 3'b000) begin errors++; $display("FAIL idle_done_ignored: got busy=%b ack=%b expected 0 000", busy, ack); end
  endtask

  task automatic test_rotation();
    int exp_idx;
    req = 3'b101;
    exp_idx = rr_pick(req, m_last);
    tick();
    checks++; if (grant !== (3'b001 << exp_idx) || eng_sel !== 2'(exp_idx)) begin errors++; $display("FAIL rotation_first: got grant=%b sel=%0d expected grant=%b sel=%0d", grant, eng_sel, 3'b001 << exp_idx, exp_idx); end
    tick(); tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    checks++; if (ack !== (3'b001 << exp_idx)) begin errors++; $display("FAIL rotation_ack1: got %b expected %b", ack, 3'b001 << exp_idx); end
    m_last = exp_idx;
    tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rotation_gap: got %b expected 000", grant); end
    exp_idx = rr_pick(req, m_last);
    tick();
    checks++; if (grant !== (3'b001 << exp_idx) || eng_start !== 1'b1) begin errors++; $display("FAIL rotation_second: got grant=%b start=%b expected grant=%b start=1", grant, eng_start, 3'b001 << exp_idx); end
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0; req = 3'b000;
    checks++; if (ack !== (3'b001 << exp_idx)) begin errors++; $display("FAIL rotation_ack2: got %b expected %b", ack, 3'b001 << exp_idx); end
    m_last = exp_idx;
    tick();
  endtask

  task automatic test_back_to_back();
    int acks;
    int cycles;
    int exp_idx;
    do_reset();
    acks = 0;
    req = 3'b111;
    for (int j = 0; j < 3; j++) begin
      cycles = 0;
      while (eng_start !== 1'b1 && cycles < 8) begin
        tick();
        cycles++;
      end
      checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL b2b_start_timeout: got start=%b expected 1 within 8 cycles", eng_start); end
      checks++; if (cycles !== ((j == 0) ? 1 : 2)) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected %0d", cycles, (j == 0) ? 1 : 2); end
      exp_idx = rr_pick(req, m_last);
      checks++; if (grant !== (3'b001 << exp_idx)) begin errors++; $display("FAIL b2b_grant: got %b expected %b", grant, 3'b001 << exp_idx); end
      repeat (4) tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      if (ack !== 3'b000) acks++;
      m_last = exp_idx;
      if (j == 2) req = 3'b000;
    end
    repeat (4) begin
      tick();
      if (ack !== 3'b000) acks++;
    end
    checks++; if (acks !== 3) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 3", acks); end
  endtask

  task automatic test_owner_drop();
    req = 3'b001;
    tick(); tick(); tick(); tick();
    req = 3'b000;
    repeat (3) begin
      tick();
      checks++; if (grant !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL drop_hold: got grant=%b busy=%b expected 001 1", grant, busy); end
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL drop_ack: got %b expected 001", ack); end
    m_last = 0;
    tick();
    repeat (3) begin
      tick();
      checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_regrant: got grant=%b busy=%b expected 000 0", grant, busy); end
    end
  endtask

  task automatic test_reset_mid();
    int exp_idx;
    req = 3'b010;
    tick(); tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || eng_sel !== 2'd0 || eng_start !== 1'b0 || ack !== 3'b000) begin errors++; $display("FAIL async_reset: got grant=%b busy=%b sel=%0d start=%b ack=%b expected all 0", grant, busy, eng_sel, eng_start, ack); end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_no_ack: got %b expected 000", ack); end
    reset = 1'b0; req = 3'b111; m_last = 2;
    exp_idx = rr_pick(req, m_last);
    tick();
    checks++; if (grant !== (3'b001 << exp_idx)) begin errors++; $display("FAIL post_reset_grant: got %b expected %b", grant, 3'b001 << exp_idx); end
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0; req = 3'b000;
    checks++; if (ack !== (3'b001 << exp_idx)) begin errors++; $display("FAIL post_reset_ack: got %b expected %b", ack, 3'b001 << exp_idx); end
    m_last = exp_idx;
    tick();
  endtask

  task automatic test_timeout();
    req = 3'b100;
    tick();
    checks++; if (eng_start !== 1'b1 || grant !== 3'b100) begin errors++; $display("FAIL tmo_start: got start=%b grant=%b expected 1 100", eng_start, grant); end
`ifdef FIR_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (eng_abort !== 1'b0 || ack !== 3'b000) begin errors++; $display("FAIL tmo_early: got abort=%b ack=%b at cycle %0d expected 0 000", eng_abort, ack, k); end
    end
    tick();
    checks++; if (eng_abort !== 1'b1 || ack !== 3'b100 || timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_fire: got abort=%b ack=%b terr=%b expected 1 100 1", eng_abort, ack, timeout_err); end
    req = 3'b000; m_last = 2;
    tick();
    checks++; if (eng_abort !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_after: got abort=%b terr=%b busy=%b expected 0 1 0", eng_abort, timeout_err, busy); end
`else
    repeat (40) begin
      tick();
      checks++; if (busy !== 1'b1 || grant !== 3'b100 || eng_abort !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL no_tmo_wait: got busy=%b grant=%b abort=%b terr=%b expected 1 100 0 0", busy, grant, eng_abort, timeout_err); end
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0; req = 3'b000;
    checks++; if (ack !== 3'b100) begin errors++; $display("FAIL no_tmo_ack: got %b expected 100", ack); end
    m_last = 2;
    tick();
`endif
  endtask

  task automatic test_random();
    logic [2:0] r;
    int exp_idx;
    int dly;
    for (int n = 0; n < 40; n++) begin
      r = 3'($urandom_range(1, 7));
      req = r;
      exp_idx = rr_pick(r, m_last);
      tick();
      checks++; if (grant !== (3'b001 << exp_idx) || eng_sel !== 2'(exp_idx) || eng_start !== 1'b1) begin errors++; $display("FAIL rand_grant: req=%b got grant=%b sel=%0d start=%b expected grant=%b sel=%0d start=1", r, grant, eng_sel, eng_start, 3'b001 << exp_idx, exp_idx); end
      eng_done = 1'($urandom_range(0, 1));
      tick();
      eng_done = 1'b0;
      checks++; if (eng_start !== 1'b0 || ack !== 3'b000) begin errors++; $display("FAIL rand_start_done: got start=%b ack=%b expected 0 000", eng_start, ack); end
      dly = $urandom_range(0, 5);
      repeat (dly) begin
        tick();
        checks++; if (ack !== 3'b000 || busy !== 1'b1 || grant !== (3'b001 << exp_idx)) begin errors++; $display("FAIL rand_busy: got ack=%b busy=%b grant=%b expected 000 1 %b", ack, busy, grant, 3'b001 << exp_idx); end
      end
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0; req = 3'b000;
      checks++; if (ack !== (3'b001 << exp_idx)) begin errors++; $display("FAIL rand_ack: got %b expected %b", ack, 3'b001 << exp_idx); end
      m_last = exp_idx;
      tick();
      checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rand_idle: got grant=%b busy=%b expected 000 0", grant, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_owner_drop();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached expected bench completion");
    $fatal(1);
  end

endmodule
